// File: rtl/proj_1d.sv
// rtl/proj_1d.sv - three-input truth-table function unit with registered output and coverage
// f = TRUTH_TABLE[{x,y,z}] (default: 3-input majority), f_q is f delayed one clock.
// Optional feature macro: PROJ1D_COVER_EN enables the seen mask, all_seen and the
// saturating ones_cnt; without it those outputs are tied to zero and the ports remain.
module proj_1d #(
  parameter logic [7:0] TRUTH_TABLE = 8'b1110_1000,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             f,
  output logic             f_q,
  output logic [7:0]       seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] ones_cnt
);

  logic [2:0] idx;

  assign idx = {x, y, z};

  // Table lookup is purely combinational so f never depends on clk or rst.
  assign f = TRUTH_TABLE[idx];

  // One-cycle registered copy of f, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f;
    end
  end

`ifdef PROJ1D_COVER_EN
  logic [7:0]       seen_r;
  logic [CNT_W-1:0] ones_cnt_r;

  // Sticky per-index coverage mask; bits only clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_r <= 8'h00;
    end else begin
      seen_r[idx] <= 1'b1;
    end
  end

  // Count clocked cycles with f high, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt_r <= '0;
    end else if (f && (ones_cnt_r != {CNT_W{1'b1}})) begin
      ones_cnt_r <= ones_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign seen     = seen_r;
  assign all_seen = &seen_r;
  assign ones_cnt = ones_cnt_r;
`else
  assign seen     = 8'h00;
  assign all_seen = 1'b0;
  assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_proj_1d.sv
// tb/tb_proj_1d.sv - table-driven and scoreboard bench for proj_1d
module tb_proj_1d;

`ifdef PROJ1D_COVER_EN
  localparam bit COV = 1'b1;
`else
  localparam bit COV = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       x;
  logic       y;
  logic       z;
  logic       f;
  logic       f_q;
  logic [7:0] seen;
  logic       all_seen;
  logic [7:0] ones_cnt;

  int checks   = 0;
  int failures = 0;

  logic exp_q[$];

  typedef struct {
    logic [2:0] in;
    logic       f_exp;
  } vec_t;

  vec_t vecs[8];

  proj_1d dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .z        (z),
    .f        (f),
    .f_q      (f_q),
    .seen     (seen),
    .all_seen (all_seen),
    .ones_cnt (ones_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] v);
    {x, y, z} = v;
  endtask

  // Push the f_q expected after the next edge, clock once, then pop and compare.
  task automatic tick_expect(input string name, input logic fq_exp);
    logic e;
    exp_q.push_back(fq_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(name, {31'd0, f_q}, {31'd0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{3'b000, 1'b0};
    vecs[1] = '{3'b001, 1'b0};
    vecs[2] = '{3'b010, 1'b0};
    vecs[3] = '{3'b011, 1'b1};
    vecs[4] = '{3'b100, 1'b0};
    vecs[5] = '{3'b101, 1'b1};
    vecs[6] = '{3'b110, 1'b1};
    vecs[7] = '{3'b111, 1'b1};

    rst = 1'b1;
    set_in(3'b000);
    tick();
    tick();
    chk("reset_f_q", {31'd0, f_q}, 32'd0);
    chk("reset_seen", {24'd0, seen}, 32'd0);
    chk("reset_all_seen", {31'd0, all_seen}, 32'd0);
    chk("reset_ones_cnt", {24'd0, ones_cnt}, 32'd0);

    // Exhaustive sweep, one index per clock.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].in);
      #1;
      chk($sformatf("sweep_f_%0d", i), {31'd0, f}, {31'd0, vecs[i].f_exp});
      tick_expect($sformatf("sweep_f_q_%0d", i), vecs[i].f_exp);
    end
    chk("sweep_seen", {24'd0, seen}, COV ? 32'hFF : 32'h0);
    chk("sweep_all_seen", {31'd0, all_seen}, {31'd0, COV});
    chk("sweep_ones_cnt", {24'd0, ones_cnt}, COV ? 32'd4 : 32'd0);

    // Single reset edge clears everything, even with f high on the inputs.
    rst = 1'b1;
    tick_expect("rst1_f_q", 1'b0);
    chk("rst1_seen", {24'd0, seen}, 32'd0);
    chk("rst1_all_seen", {31'd0, all_seen}, 32'd0);
    chk("rst1_ones_cnt", {24'd0, ones_cnt}, 32'd0);

    // Mid-cycle input change: f moves at once, f_q waits for the edge.
    rst = 1'b0;
    set_in(3'b011);
    tick_expect("mid_f_q_a", 1'b1);
    chk("mid_seen_first", {24'd0, seen}, COV ? 32'h08 : 32'h0);
    #2;
    set_in(3'b100);
    #1;
    chk("mid_f_drop", {31'd0, f}, 32'd0);
    chk("mid_f_q_hold", {31'd0, f_q}, 32'd1);
    tick_expect("mid_f_q_b", 1'b0);

    // Saturation: hold 110 for 300 cycles after a reset taken with 110 applied.
    rst = 1'b1;
    set_in(3'b110);
    tick_expect("sat_rst_f_q", 1'b0);
    chk("sat_rst_seen", {24'd0, seen}, 32'd0);
    rst = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 100 || n == 254 || n == 255 || n == 256 || n == 300) begin
        chk($sformatf("sat_cnt_%0d", n), {24'd0, ones_cnt},
            COV ? ((n > 255) ? 32'd255 : n) : 32'd0);
      end
    end
    chk("sat_seen", {24'd0, seen}, COV ? 32'h40 : 32'h0);
    chk("sat_all_seen", {31'd0, all_seen}, 32'd0);
    chk("sat_f_q", {31'd0, f_q}, 32'd1);

    // Reset held while sweeping: f tracks, state stays cleared.
    rst = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      set_in(vecs[i].in);
      #1;
      chk($sformatf("rsthold_f_%0d", i), {31'd0, f}, {31'd0, vecs[i].f_exp});
      tick_expect($sformatf("rsthold_f_q_%0d", i), 1'b0);
      chk($sformatf("rsthold_seen_%0d", i), {24'd0, seen}, 32'd0);
      chk($sformatf("rsthold_cnt_%0d", i), {24'd0, ones_cnt}, 32'd0);
    end

    // Counting resumes on the first edge after reset release.
    rst = 1'b0;
    set_in(3'b111);
    tick_expect("resume_f_q", 1'b1);
    chk("resume_cnt", {24'd0, ones_cnt}, COV ? 32'd1 : 32'd0);
    chk("resume_seen", {24'd0, seen}, COV ? 32'h80 : 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
